// File: rtl/rtc_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_pkg
//  Description : Shared types and constants for the RTC bus controller:
//                FSM state encoding, default phase length and the init
//                write table.
//  Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

    localparam int T_PHASE_DEFAULT  = 10;
    localparam int INIT_LEN_DEFAULT = 2;

    // Init table contents
    localparam logic [7:0] INIT_ADDR0 = 8'h02;
    localparam logic [7:0] INIT_DATA0 = 8'h10;
    localparam logic [7:0] INIT_ADDR1 = 8'h02;
    localparam logic [7:0] INIT_DATA1 = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_GAP1      = 3'd2,
        ST_DATA      = 3'd3,
        ST_GAP2      = 3'd4,
        ST_DONE      = 3'd5,
        ST_INIT_NEXT = 3'd6
    } rtc_state_e;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } rtc_init_entry_t;

    // Table lookup; indices past the table repeat the last entry.
    function automatic rtc_init_entry_t init_entry(input logic [7:0] idx);
        rtc_init_entry_t e;
        case (idx)
            8'd0:    e = '{addr: INIT_ADDR0, data: INIT_DATA0};
            default: e = '{addr: INIT_ADDR1, data: INIT_DATA1};
        endcase
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_ctrl_if
//  Description : Request side and RTC pad side signals of the RTC bus
//                controller. master = host/pads, slave = controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rtc_bus_ctrl_if;

    logic       inicializacion;
    logic       inicio_escritura;
    logic       inicio_lectura;
    logic [7:0] dir;
    logic [7:0] dato_wr;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;
    logic [7:0] dato_rd;
    logic       fin_tx;
    logic       fin_init;

    modport master (
        output inicializacion, inicio_escritura, inicio_lectura,
        output dir, dato_wr, ad_in,
        input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d,
        input  dato_rd, fin_tx, fin_init
    );

    modport slave (
        input  inicializacion, inicio_escritura, inicio_lectura,
        input  dir, dato_wr, ad_in,
        output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d,
        output dato_rd, fin_tx, fin_init
    );

endinterface
`default_nettype wire

// File: rtl/rtc_bus_ctrl_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_timer
//  Description : Loadable 8-bit down counter; tc is high while the count
//                is zero, marking the last cycle of a bus phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_timer (
    input  wire logic       CLK,
    input  wire logic       reset,
    input  wire logic       load,
    input  wire logic [7:0] load_val,
    output logic            tc
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Load wins; otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == 8'd0);

endmodule
`default_nettype wire

// File: rtl/rtc_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_ctrl
//  Description : Sequencer for a multiplexed address/data RTC bus. Runs
//                single writes, single reads and an init table of writes,
//                each as ADDR/GAP1/DATA/GAP2 phases of T_PHASE cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_ctrl
    import rtc_pkg::*;
#(
    parameter int T_PHASE  = T_PHASE_DEFAULT,
    parameter int INIT_LEN = INIT_LEN_DEFAULT
) (
    input  wire logic     CLK,
    input  wire logic     reset,
    rtc_bus_ctrl_if.slave bus
);

    localparam logic [7:0] PHASE_LOAD = 8'(T_PHASE - 1);
    localparam logic [7:0] INIT_LAST  = 8'(INIT_LEN - 1);

    rtc_state_e state_q, state_d;
    logic       op_rd_q, op_rd_d;         // 1 = read, 0 = write
    logic       init_mode_q, init_mode_d; // current write comes from init table
    logic [7:0] init_idx_q, init_idx_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] dato_rd_q, dato_rd_d;
    logic       fin_init_q, fin_init_d;

    logic            timer_load;
    logic            timer_tc;
    rtc_init_entry_t init_first;
    rtc_init_entry_t init_next;

    assign init_first = init_entry(8'd0);
    assign init_next  = init_entry(init_idx_q + 8'd1);

    phase_timer u_phase_timer (
        .CLK      (CLK),
        .reset    (reset),
        .load     (timer_load),
        .load_val (PHASE_LOAD),
        .tc       (timer_tc)
    );

    // Next-state logic: request arbitration in IDLE, phase sequencing on tc.
    always_comb begin
        state_d     = state_q;
        op_rd_d     = op_rd_q;
        init_mode_d = init_mode_q;
        init_idx_d  = init_idx_q;
        addr_d      = addr_q;
        data_d      = data_q;
        dato_rd_d   = dato_rd_q;
        fin_init_d  = fin_init_q;
        timer_load  = 1'b0;

        if (fin_init_q && !bus.inicializacion) begin
            fin_init_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.inicializacion && !fin_init_q) begin
                    addr_d      = init_first.addr;
                    data_d      = init_first.data;
                    op_rd_d     = 1'b0;
                    init_mode_d = 1'b1;
                    init_idx_d  = 8'd0;
                    state_d     = ST_ADDR;
                    timer_load  = 1'b1;
                end else if (bus.inicio_escritura) begin
                    addr_d      = bus.dir;
                    data_d      = bus.dato_wr;
                    op_rd_d     = 1'b0;
                    init_mode_d = 1'b0;
                    state_d     = ST_ADDR;
                    timer_load  = 1'b1;
                end else if (bus.inicio_lectura) begin
                    addr_d      = bus.dir;
                    data_d      = bus.dato_wr;
                    op_rd_d     = 1'b1;
                    init_mode_d = 1'b0;
                    state_d     = ST_ADDR;
                    timer_load  = 1'b1;
                end
            end
            ST_ADDR: begin
                if (timer_tc) begin
                    state_d    = ST_GAP1;
                    timer_load = 1'b1;
                end
            end
            ST_GAP1: begin
                if (timer_tc) begin
                    state_d    = ST_DATA;
                    timer_load = 1'b1;
                end
            end
            ST_DATA: begin
                if (timer_tc) begin
                    if (op_rd_q) begin
                        dato_rd_d = bus.ad_in;
                    end
                    state_d    = ST_GAP2;
                    timer_load = 1'b1;
                end
            end
            ST_GAP2: begin
                if (timer_tc) begin
                    state_d = init_mode_q ? ST_INIT_NEXT : ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_INIT_NEXT: begin
                if (init_idx_q >= INIT_LAST) begin
                    fin_init_d  = 1'b1;
                    init_mode_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    init_idx_d = init_idx_q + 8'd1;
                    addr_d     = init_next.addr;
                    data_d     = init_next.data;
                    state_d    = ST_ADDR;
                    timer_load = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched-transaction registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_rd_q     <= 1'b0;
            init_mode_q <= 1'b0;
            init_idx_q  <= 8'd0;
            addr_q      <= 8'd0;
            data_q      <= 8'd0;
            dato_rd_q   <= 8'd0;
            fin_init_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_rd_q     <= op_rd_d;
            init_mode_q <= init_mode_d;
            init_idx_q  <= init_idx_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            dato_rd_q   <= dato_rd_d;
            fin_init_q  <= fin_init_d;
        end
    end

    // Pad and strobe decode from the current state; a read never drives the pads
    // once the address phase is over.
    always_comb begin
        bus.cs_n   = 1'b1;
        bus.rd_n   = 1'b1;
        bus.wr_n   = 1'b1;
        bus.ad_oe  = 1'b0;
        bus.a_d    = 1'b0;
        bus.ad_out = 8'h00;
        bus.fin_tx = 1'b0;
        case (state_q)
            ST_ADDR: begin
                bus.cs_n   = 1'b0;
                bus.wr_n   = 1'b0;
                bus.ad_oe  = 1'b1;
                bus.ad_out = addr_q;
            end
            ST_GAP1: begin
                bus.cs_n   = 1'b0;
                bus.ad_oe  = !op_rd_q;
                bus.ad_out = op_rd_q ? 8'h00 : addr_q;
            end
            ST_DATA: begin
                bus.cs_n = 1'b0;
                bus.a_d  = 1'b1;
                if (op_rd_q) begin
                    bus.rd_n = 1'b0;
                end else begin
                    bus.wr_n   = 1'b0;
                    bus.ad_oe  = 1'b1;
                    bus.ad_out = data_q;
                end
            end
            ST_DONE: begin
                bus.fin_tx = !init_mode_q;
            end
            default: begin
            end
        endcase
    end

    assign bus.dato_rd  = dato_rd_q;
    assign bus.fin_init = fin_init_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtc_bus_ctrl
//  Description : Scoreboard bench for rtc_bus_ctrl with T_PHASE=4. Stimulus
//                pushes expected bus transactions; a bus monitor pops and
//                compares them as they appear on the pads.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rtc_bus_ctrl;

    localparam int TP  = 4;
    localparam int LAT = 4 * TP + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rtc_bus_ctrl_if bus ();

    rtc_bus_ctrl #(
        .T_PHASE  (TP),
        .INIT_LEN (2)
    ) dut (
        .CLK   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       is_wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic       fin;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   viol   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Pad protocol: strobes never both low, pads never driven during a read strobe.
    always @(negedge clk) begin
        if ((!bus.rd_n && !bus.wr_n) || (bus.ad_oe && !bus.rd_n)) viol++;
    end

    // Bus monitor: rebuilds each transaction from the pads and checks it.
    logic       mon_in_txn = 1'b0;
    logic       pending    = 1'b0;
    int         mon_cyc    = 0;
    int         addr_cnt   = 0;
    int         data_cnt   = 0;
    logic [7:0] mon_addr   = 8'h00;
    logic [7:0] mon_data   = 8'h00;
    logic       mon_wr     = 1'b0;
    logic       mon_rd     = 1'b0;
    logic       mon_oe_ok  = 1'b1;
    exp_t       last;

    always @(negedge clk) begin
        if (rst) begin
            mon_in_txn = 1'b0;
            pending    = 1'b0;
        end else begin
            mon_cyc++;
            if (!mon_in_txn && !bus.cs_n) begin
                mon_in_txn = 1'b1;
                mon_cyc    = 0;
                addr_cnt   = 0;
                data_cnt   = 0;
                mon_wr     = 1'b0;
                mon_rd     = 1'b0;
                mon_oe_ok  = 1'b1;
            end
            if (mon_in_txn && !bus.cs_n) begin
                if (!bus.a_d && !bus.wr_n) begin
                    addr_cnt++;
                    mon_addr = bus.ad_out;
                    if (!bus.ad_oe) mon_oe_ok = 1'b0;
                end else if (bus.a_d && !bus.wr_n) begin
                    data_cnt++;
                    mon_data = bus.ad_out;
                    mon_wr   = 1'b1;
                    if (!bus.ad_oe) mon_oe_ok = 1'b0;
                end else if (bus.a_d && !bus.rd_n) begin
                    data_cnt++;
                    mon_rd = 1'b1;
                end
            end else if (mon_in_txn && bus.cs_n) begin
                mon_in_txn = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected bus txn", 32'd1, 32'd0);
                end else begin
                    last = sb.pop_front();
                    check("txn op", {mon_wr, mon_rd}, {last.is_wr, !last.is_wr});
                    check("txn addr", mon_addr, last.addr);
                    if (last.is_wr) check("txn wdata", mon_data, last.data);
                    check("phase lengths", {addr_cnt[7:0], data_cnt[7:0], mon_oe_ok},
                          {8'(TP), 8'(TP), 1'b1});
                    pending = last.fin;
                end
            end
            if (bus.fin_tx) begin
                if (!pending) begin
                    check("unexpected fin_tx", 32'd1, 32'd0);
                end else begin
                    check("fin_tx timing", mon_cyc, 4 * TP);
                    if (!last.is_wr) check("dato_rd at fin_tx", bus.dato_rd, last.data);
                    pending = 1'b0;
                end
            end else if (pending && mon_cyc > 4 * TP) begin
                check("missing fin_tx", mon_cyc, 4 * TP);
                pending = 1'b0;
            end
        end
    end

    // Count cycles until fin_tx; entered on the first negedge after sampling.
    task automatic wait_fin(output int n);
        n = 1;
        while (!bus.fin_tx && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        int n;
        sb.push_back('{1'b1, a, d, 1'b1});
        @(negedge clk);
        bus.dir = a; bus.dato_wr = d; bus.inicio_escritura = 1'b1;
        @(negedge clk);
        bus.inicio_escritura = 1'b0; bus.dir = 8'h00; bus.dato_wr = 8'h00;
        wait_fin(n);
        check("write latency", n, LAT);
        @(negedge clk);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] d);
        int n;
        sb.push_back('{1'b0, a, d, 1'b1});
        @(negedge clk);
        bus.dir = a; bus.ad_in = d; bus.inicio_lectura = 1'b1;
        @(negedge clk);
        bus.inicio_lectura = 1'b0; bus.dir = 8'h00;
        wait_fin(n);
        check("read latency", n, LAT);
        repeat (3) @(negedge clk);
        bus.ad_in = 8'h00;
        @(negedge clk);
        check("dato_rd hold", bus.dato_rd, d);
    endtask

    initial begin
        int n;
        int g;
        int fins;
        bus.inicializacion   = 1'b0;
        bus.inicio_escritura = 1'b0;
        bus.inicio_lectura   = 1'b0;
        bus.dir              = 8'h00;
        bus.dato_wr          = 8'h00;
        bus.ad_in            = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset strobes", {bus.cs_n, bus.rd_n, bus.wr_n, bus.ad_oe, bus.a_d,
                                bus.fin_tx, bus.fin_init}, 7'b1110000);
        check("reset ad_out", bus.ad_out, 8'h00);
        check("reset dato_rd", bus.dato_rd, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Single write and single read
        do_write(8'h21, 8'h45);
        do_read(8'h22, 8'h37);

        // Init table: two writes, no fin_tx, fin_init held until request drops
        sb.push_back('{1'b1, 8'h02, 8'h10, 1'b0});
        sb.push_back('{1'b1, 8'h02, 8'h00, 1'b0});
        @(negedge clk);
        bus.inicializacion = 1'b1;
        n = 0;
        while (!bus.fin_init && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("fin_init set", bus.fin_init, 1'b1);
        repeat (20) @(negedge clk);
        check("fin_init held", bus.fin_init, 1'b1);
        check("init writes seen", sb.size(), 0);
        bus.inicializacion = 1'b0;
        repeat (2) @(negedge clk);
        check("fin_init cleared", bus.fin_init, 1'b0);

        // Simultaneous write+read: write first, read after DONE + one IDLE
        sb.push_back('{1'b1, 8'h30, 8'hA5, 1'b1});
        sb.push_back('{1'b0, 8'h31, 8'h5C, 1'b1});
        @(negedge clk);
        bus.dir = 8'h30; bus.dato_wr = 8'hA5; bus.ad_in = 8'h5C;
        bus.inicio_escritura = 1'b1; bus.inicio_lectura = 1'b1;
        @(negedge clk);
        bus.inicio_escritura = 1'b0; bus.dir = 8'h31;
        wait_fin(n);
        check("priority write latency", n, LAT);
        g = 0;
        while (bus.cs_n && g < 10) begin
            @(negedge clk);
            g++;
        end
        check("gap before read", g, 2);
        bus.inicio_lectura = 1'b0;
        wait_fin(n);
        check("queued read latency", n, LAT);
        repeat (2) @(negedge clk);

        // Reset during DATA of a write
        bus.dir = 8'h40; bus.dato_wr = 8'h99; bus.inicio_escritura = 1'b1;
        @(negedge clk);
        bus.inicio_escritura = 1'b0;
        n = 0;
        while (!(bus.a_d && !bus.wr_n) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("reached write DATA", {bus.a_d, bus.wr_n}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        check("reset release", {bus.cs_n, bus.rd_n, bus.wr_n, bus.ad_oe, bus.a_d,
                                bus.fin_tx}, 6'b111000);
        check("reset clears dato_rd", bus.dato_rd, 8'h00);
        rst = 1'b0;
        fins = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.fin_tx) fins++;
        end
        check("no fin_tx after reset", fins, 0);

        // Normal operation after reset
        do_read(8'h0F, 8'hE1);
        do_write(8'hFF, 8'h00);

        repeat (5) @(negedge clk);
        check("scoreboard drained", sb.size(), 0);
        check("protocol violations", viol, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rtc_bus_ctrl.md
RTC_BUS_CTRL -- requirements
Module: rtc_bus_ctrl

Interface
REQ-001 Parameter: T_PHASE, 10, length in CLK cycles of every bus phase; legal range 2..255.
REQ-002 Parameter: INIT_LEN, 2, number of entries in the init write table.
REQ-003 CLK  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 inicializacion  in  1  level request: run the init table.
REQ-006 inicio_escritura  in  1  level request: single register write.
REQ-007 inicio_lectura  in  1  level request: single register read.
REQ-008 dir  in  8  RTC register address for write/read.
REQ-009 dato_wr  in  8  write data.
REQ-010 ad_in  in  8  pad input of the multiplexed address/data bus.
REQ-011 ad_out  out  8  pad output of the multiplexed bus.
REQ-012 ad_oe  out  1  pad drive enable; 1 = drive ad_out.
REQ-013 cs_n, rd_n, wr_n  out  1 each  active-low chip select, read strobe and write strobe.
REQ-014 a_d  out  1  0 = address phase, 1 = data phase.
REQ-015 dato_rd  out  8  last data read; holds until the next read.
REQ-016 fin_tx  out  1  one-cycle pulse at the end of every write or read transaction (feeds Bandfin_wr).
REQ-017 fin_init  out  1  level; 1 after the init table completes, cleared when inicializacion falls (feeds BandFin).

Function
REQ-018 States SHALL be IDLE, ADDR, GAP1, DATA, GAP2, DONE, with INIT_NEXT used only during initialisation.
REQ-019 Requests SHALL be sampled only in IDLE, with priority inicializacion > inicio_escritura > inicio_lectura; a sampled request latches dir, dato_wr and op type.
REQ-020 ADDR (T_PHASE cycles): cs_n=0, a_d=0, wr_n=0, ad_oe=1, ad_out=latched address.
REQ-021 GAP1 (T_PHASE cycles): cs_n=0, wr_n=1, rd_n=1; ad_oe stays 1 for writes and falls to 0 for reads.
REQ-022 DATA (T_PHASE cycles): a_d=1, cs_n=0; write: wr_n=0, ad_oe=1, ad_out=data; read: rd_n=0, ad_oe=0.
REQ-023 Read data SHALL be captured from ad_in into dato_rd on the last DATA cycle.
REQ-024 GAP2 (T_PHASE cycles): cs_n=1, all strobes high, ad_oe=0.
REQ-025 DONE SHALL last 1 cycle: fin_tx=1 for write/read, then return to IDLE.
REQ-026 Latency from the IDLE sampling edge to the fin_tx pulse SHALL be exactly 4*T_PHASE+1 cycles.
REQ-027 Init SHALL issue INIT_LEN back-to-back writes from the table without fin_tx pulses, then set fin_init; no new init is started while fin_init=1.
REQ-028 Requests still high after DONE SHALL start a new transaction on the next IDLE cycle, one idle cycle minimum between transactions.
REQ-029 Request deassertion mid-transaction SHALL NOT abort it; the transaction completes.
REQ-030 rd_n and wr_n SHALL never be 0 simultaneously; ad_oe SHALL be 0 whenever rd_n=0.

Reset
REQ-031 Reset SHALL force IDLE at any state and set cs_n=rd_n=wr_n=1, ad_oe=0, a_d=0, ad_out=0, dato_rd=0, fin_tx=0, fin_init=0, and the phase counter to 0.
REQ-032 Reset mid-transaction SHALL release the bus on the next edge, with no fin_tx pulse.

Structure
REQ-033 Package rtc_pkg SHALL hold the state encoding, T_PHASE default, and init table constants (entry0 addr 0x02 data 0x10; entry1 addr 0x02 data 0x00).
REQ-034 Sub-module phase_timer (loadable 8-bit down counter with a terminal-count output) SHALL time every phase.

Verification (T_PHASE=4)
REQ-035 Write dir=0x21, dato_wr=0x45 -> ADDR with ad_out=0x21, then DATA with ad_out=0x45 and wr_n=0 for 4 cycles each; fin_tx pulses 17 cycles after sampling.
REQ-036 Read dir=0x22 with ad_in=0x37 -> rd_n=0 and ad_oe=0 during DATA; dato_rd=0x37 and fin_tx pulses at cycle 17.
REQ-037 inicializacion=1 -> two writes 0x02/0x10 then 0x02/0x00 with no fin_tx; fin_init=1 holds, then clears when inicializacion=0.
REQ-038 inicio_escritura and inicio_lectura both high in IDLE -> write runs first; read follows after DONE plus one IDLE cycle.
REQ-039 reset during DATA of a write -> next cycle cs_n=wr_n=1, ad_oe=0, state IDLE, no fin_tx pulse.
REQ-040 Assertion check over all tests: never rd_n=wr_n=0 together, and never ad_oe=1 while rd_n=0.
